pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the lock inputs of the PC and of the IF/ID, ID/EX and EX/MEM buffers.
- Drives the flush (bubble) controls of IF/ID and ID/EX.
- Resolves load-use hazards, multi-cycle memory waits, taken-branch squashes and halt drain, then raises a sticky `halted` once every older instruction has retired.

Parameters:
- LOAD_USE_STALL, 1, bubble cycles inserted per load-use hazard (legal range 1..7).
- DRAIN_CYCLES, 3, cycles from halt-in-ID until WB has retired all older instructions (legal range 1..7).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst_b  input  1  reset, synchronous, active-high (1 = reset).
- id_rs  input  5  rs field of instruction in ID.
- id_rt  input  5  rt field of instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- ex_rt  input  5  destination rt of instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- branch_taken_ex  input  1  branch/jump in EX resolved taken.
- mem_busy  input  1  data memory not ready this cycle.
- halted_controller_id  input  1  halt instruction currently in ID.
- lock_pc  output  1  hold PC.
- lock_if_id  output  1  hold IF/ID buffer.
- lock_id_ex  output  1  hold ID/EX buffer.
- lock_ex_mem  output  1  hold EX/MEM buffer.
- flush_if_id  output  1  load NOP/zero into IF/ID next edge.
- flush_id_ex  output  1  load bubble into ID/EX next edge.
- halted  output  1  pipeline drained after halt; sticky.

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT, DRAIN, HALTED. Outputs are combinational from state plus current inputs; state and counters are registered.
- Reset: state=RUN, counters=0, halted=0. While rst_b=1, all locks and flushes are 0. Reset asserted in any state, including HALTED, returns to RUN on the next edge.
- hazard = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Priority in RUN, highest first: mem_busy > branch_taken_ex > halted_controller_id > hazard.
- mem_busy=1 (any non-HALTED state):
  - lock_pc, lock_if_id, lock_id_ex and lock_ex_mem are all 1; both flushes are 0.
  - The previous state is saved; the machine enters MEM_WAIT and stays while mem_busy=1.
  - On the first cycle with mem_busy=0 it returns to the saved state. The return cycle re-evaluates inputs, which frozen stages hold stable.
  - LOAD_STALL and DRAIN counters do not advance while busy.
- branch_taken_ex in RUN:
  - flush_if_id=1 and flush_id_ex=1 for exactly that cycle; no locks.
  - Overrides hazard and halt in the same cycle, since those ID instructions are wrong-path.
  - Stays RUN.
- hazard in RUN:
  - lock_pc=1, lock_if_id=1, flush_id_ex=1.
  - If LOAD_USE_STALL==1, stays RUN; the hazard has cleared by the next cycle.
  - Otherwise goes to LOAD_STALL with cnt=LOAD_USE_STALL-1.
- LOAD_STALL:
  - Same outputs as the hazard cycle; cnt decrements each cycle.
  - At cnt==1 the next state is RUN.
  - branch_taken_ex cannot occur here, because EX holds a bubble or the load.
- halted_controller_id in RUN (no mem_busy, no branch):
  - lock_pc=1, flush_if_id=1, flush_id_ex=1 from that cycle onward.
  - Goes to DRAIN with cnt=DRAIN_CYCLES.
- DRAIN:
  - lock_pc=1, flush_if_id=1, flush_id_ex=1; cnt decrements.
  - At cnt==1 the next state is HALTED.
- HALTED:
  - halted=1; all four locks are 1; flushes are 0.
  - Ignores every input, including mem_busy; leaves only on reset.
- Counters are 3 bits; parameter values outside 1..7 fail an elaboration-time assertion. No wrap-around is possible in legal use.

Optional Feature:
- Macro HAZARD_PERF_COUNT_EN.
- When defined, adds outputs:
  - stall_cycles[31:0]: +1 per cycle with lock_pc=1 in RUN/LOAD_STALL/MEM_WAIT.
  - flush_count[31:0]: +1 per branch flush.
- Both counters clear on reset, saturate at 32'hFFFF_FFFF, and freeze in HALTED.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Package hazard_pkg holds:
  - state enum hz_state_t (RUN, LOAD_STALL, MEM_WAIT, DRAIN, HALTED).
  - REG_ZERO=5'd0, REG_ADDR_W=5 and CNT_W=3.
- One sub-module, hz_down_counter:
  - Loadable 3-bit down-counter with load, enable and done (cnt==1).
  - Instantiated twice, for the stall and drain counts.

Test Plan:
1. Load into $t0 in EX (ex_rt=8, ex_mem_read=1), ID has id_rs=8 → exactly 1 cycle of lock_pc=lock_if_id=flush_id_ex=1, then all 0; with ex_rt=0 → no stall.
2. LOAD_USE_STALL=3 with a hazard, and mem_busy=1 for 2 cycles in the middle of the stall → 3 stall cycles plus 2 full-lock cycles, 5 cycles total, counter paused during busy.
3. branch_taken_ex=1 together with hazard=1 and halted_controller_id=1 → one cycle of flush_if_id=flush_id_ex=1, no locks, state stays RUN, halted never asserts.
4. halted_controller_id=1 with DRAIN_CYCLES=3 → lock_pc=1 immediately, halted=1 on the 4th edge with all locks=1; later toggling of mem_busy/branch has no effect.
5. rst_b=1 for one cycle while HALTED → next cycle halted=0, all outputs 0, state RUN.
6. With HAZARD_PERF_COUNT_EN defined, run 2 load-use stalls plus 1 branch → stall_cycles=2, flush_count=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t  : sequencer state (RUN, LOAD_STALL, MEM_WAIT, DRAIN, HALTED)
//   REG_ZERO    : architectural $zero register index (never a real dependency)
//   REG_ADDR_W  : register index width
//   CNT_W       : width of the stall / drain down-counters
//   load_use_hazard() : load-use dependency detect between EX and ID
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 3;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [2:0] {
      RUN        = 3'd0,
      LOAD_STALL = 3'd1,
      MEM_WAIT   = 3'd2,
      DRAIN      = 3'd3,
      HALTED     = 3'd4
   } hz_state_t;

   // A load in EX whose destination is read by the ID instruction. Writes to
   // $zero are discarded by the register file, so they never create a hazard.
   function automatic logic load_use_hazard(
      input logic                  ex_mem_read,
      input logic [REG_ADDR_W-1:0] ex_rt,
      input logic [REG_ADDR_W-1:0] id_rs,
      input logic [REG_ADDR_W-1:0] id_rt,
      input logic                  id_uses_rt
   );
      return ex_mem_read && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/hz_down_counter.sv
// -----------------------------------------------------------------------------
// hz_down_counter
// Loadable down-counter used to time multi-cycle stall and drain sequences.
// Ports:
//   clk      : clock, rising edge
//   rst_b    : synchronous reset, active-high; clears the count
//   load     : load load_val this edge (wins over en)
//   load_val : value to load
//   en       : decrement this edge (holds at zero)
//   done     : count currently equals 1, i.e. this is the last counted cycle
// -----------------------------------------------------------------------------
module hz_down_counter
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst_b) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Resolves
// load-use hazards, multi-cycle memory waits, taken-branch squashes and the
// halt drain, then raises a sticky `halted`.
//
// Parameters:
//   LOAD_USE_STALL : bubble cycles per load-use hazard (1..7)
//   DRAIN_CYCLES   : cycles from halt-in-ID until all older instrs retired (1..7)
//
// Ports:
//   clk, rst_b            : clock / synchronous active-high reset
//   id_rs, id_rt          : source fields of the ID instruction
//   id_uses_rt            : ID instruction reads rt
//   ex_rt, ex_mem_read    : destination and load flag of the EX instruction
//   branch_taken_ex       : branch/jump in EX resolved taken
//   mem_busy              : data memory not ready this cycle
//   halted_controller_id  : halt instruction in ID
//   lock_pc, lock_if_id, lock_id_ex, lock_ex_mem : stage hold controls
//   flush_if_id, flush_id_ex                     : bubble insert controls
//   halted                : pipeline drained after halt (sticky until reset)
//   state_dbg             : current sequencer state, for observation
//
// Optional build macro HAZARD_PERF_COUNT_EN adds:
//   stall_cycles[31:0] : cycles with lock_pc in RUN/LOAD_STALL/MEM_WAIT
//   flush_count[31:0]  : number of taken-branch flushes
//
// All outputs are combinational from the registered state and current inputs.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_USE_STALL = 1,
   parameter int DRAIN_CYCLES   = 3
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  ex_mem_read,
   input  logic                  branch_taken_ex,
   input  logic                  mem_busy,
   input  logic                  halted_controller_id,
   output logic                  lock_pc,
   output logic                  lock_if_id,
   output logic                  lock_id_ex,
   output logic                  lock_ex_mem,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  halted,
   output hz_state_t             state_dbg
`ifdef HAZARD_PERF_COUNT_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_count
`endif
);

   // Counters are CNT_W bits wide; out-of-range values would wrap.
   if ((LOAD_USE_STALL < 1) || (LOAD_USE_STALL > 7)) begin : g_bad_load_use_stall
      $error("pipeline_hazard_ctrl: LOAD_USE_STALL must be in 1..7");
   end
   if ((DRAIN_CYCLES < 1) || (DRAIN_CYCLES > 7)) begin : g_bad_drain_cycles
      $error("pipeline_hazard_ctrl: DRAIN_CYCLES must be in 1..7");
   end

   hz_state_t state_q, state_d;
   hz_state_t saved_q, saved_d;
   hz_state_t eff_state;

   logic hazard;
   logic stall_load, stall_en, stall_done;
   logic drain_load, drain_en, drain_done;
   logic branch_flush;

   assign hazard = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

   // The cycle mem_busy drops, MEM_WAIT behaves exactly as the saved state so
   // the resumed sequence loses no cycle. Frozen stages keep the inputs stable.
   assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q <= RUN;
         saved_q <= RUN;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      saved_d      = saved_q;
      lock_pc      = 1'b0;
      lock_if_id   = 1'b0;
      lock_id_ex   = 1'b0;
      lock_ex_mem  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      halted       = 1'b0;
      branch_flush = 1'b0;
      stall_load   = 1'b0;
      stall_en     = 1'b0;
      drain_load   = 1'b0;
      drain_en     = 1'b0;

      if (rst_b) begin
         state_d = RUN;
         saved_d = RUN;
      end else if (state_q == HALTED) begin
         // Terminal: ignores everything, including mem_busy.
         lock_pc     = 1'b1;
         lock_if_id  = 1'b1;
         lock_id_ex  = 1'b1;
         lock_ex_mem = 1'b1;
         halted      = 1'b1;
      end else if (mem_busy) begin
         lock_pc     = 1'b1;
         lock_if_id  = 1'b1;
         lock_id_ex  = 1'b1;
         lock_ex_mem = 1'b1;
         if (state_q != MEM_WAIT) begin
            saved_d = state_q;
         end
         state_d = MEM_WAIT;
      end else begin
         case (eff_state)
            RUN: begin
               state_d = RUN;
               if (branch_taken_ex) begin
                  // ID/IF hold wrong-path instructions; hazard and halt there
                  // are irrelevant.
                  flush_if_id  = 1'b1;
                  flush_id_ex  = 1'b1;
                  branch_flush = 1'b1;
               end else if (halted_controller_id) begin
                  lock_pc     = 1'b1;
                  flush_if_id = 1'b1;
                  flush_id_ex = 1'b1;
                  drain_load  = 1'b1;
                  state_d     = DRAIN;
               end else if (hazard) begin
                  lock_pc     = 1'b1;
                  lock_if_id  = 1'b1;
                  flush_id_ex = 1'b1;
                  if (LOAD_USE_STALL > 1) begin
                     stall_load = 1'b1;
                     state_d    = LOAD_STALL;
                  end
               end
            end
            LOAD_STALL: begin
               lock_pc     = 1'b1;
               lock_if_id  = 1'b1;
               flush_id_ex = 1'b1;
               stall_en    = 1'b1;
               state_d     = stall_done ? RUN : LOAD_STALL;
            end
            DRAIN: begin
               lock_pc     = 1'b1;
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               drain_en    = 1'b1;
               state_d     = drain_done ? HALTED : DRAIN;
            end
            default: begin
               // saved_q never holds MEM_WAIT or HALTED; recover to RUN.
               state_d = RUN;
            end
         endcase
      end
   end

   assign state_dbg = state_q;

   hz_down_counter u_stall_cnt (
      .clk      (clk),
      .rst_b    (rst_b),
      .load     (stall_load),
      .load_val (CNT_W'(LOAD_USE_STALL - 1)),
      .en       (stall_en),
      .done     (stall_done)
   );

   hz_down_counter u_drain_cnt (
      .clk      (clk),
      .rst_b    (rst_b),
      .load     (drain_load),
      .load_val (CNT_W'(DRAIN_CYCLES)),
      .en       (drain_en),
      .done     (drain_done)
   );

`ifdef HAZARD_PERF_COUNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_count_q;
   logic        stall_count_hit;

   assign stall_count_hit = lock_pc &&
                            ((state_q == RUN) || (state_q == LOAD_STALL) ||
                             (state_q == MEM_WAIT));

   always_ff @(posedge clk) begin
      if (rst_b) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else if (state_q != HALTED) begin
         if (stall_count_hit && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (branch_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_q <= flush_count_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Two instances share the inputs:
// dut (defaults: LOAD_USE_STALL=1, DRAIN_CYCLES=3) and dut3 (LOAD_USE_STALL=3).
// Output vector layout for checks: {0, lock_pc, lock_if_id, lock_id_ex,
// lock_ex_mem, flush_if_id, flush_id_ex, halted}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   logic       clk = 1'b0;
   logic       rst_b;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, branch_taken_ex, mem_busy, halted_controller_id;

   logic lp1, lif1, lie1, lem1, fif1, fie1, h1;
   logic lp3, lif3, lie3, lem3, fif3, fie3, h3;
   hz_state_t st1, st3;
`ifdef HAZARD_PERF_COUNT_EN
   logic [31:0] sc1, fc1, sc3, fc3;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] O_IDLE   = 32'h00;
   localparam logic [31:0] O_STALL  = 32'h62;
   localparam logic [31:0] O_BUSY   = 32'h78;
   localparam logic [31:0] O_BRANCH = 32'h06;
   localparam logic [31:0] O_DRAIN  = 32'h46;
   localparam logic [31:0] O_HALTED = 32'h79;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst_b(rst_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .branch_taken_ex(branch_taken_ex),
      .mem_busy(mem_busy), .halted_controller_id(halted_controller_id),
      .lock_pc(lp1), .lock_if_id(lif1), .lock_id_ex(lie1), .lock_ex_mem(lem1),
      .flush_if_id(fif1), .flush_id_ex(fie1), .halted(h1), .state_dbg(st1)
`ifdef HAZARD_PERF_COUNT_EN
      , .stall_cycles(sc1), .flush_count(fc1)
`endif
   );

   pipeline_hazard_ctrl #(.LOAD_USE_STALL(3), .DRAIN_CYCLES(3)) dut3 (
      .clk(clk), .rst_b(rst_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .branch_taken_ex(branch_taken_ex),
      .mem_busy(mem_busy), .halted_controller_id(halted_controller_id),
      .lock_pc(lp3), .lock_if_id(lif3), .lock_id_ex(lie3), .lock_ex_mem(lem3),
      .flush_if_id(fif3), .flush_id_ex(fie3), .halted(h3), .state_dbg(st3)
`ifdef HAZARD_PERF_COUNT_EN
      , .stall_cycles(sc3), .flush_count(fc3)
`endif
   );

   function automatic logic [31:0] o1();
      return {25'd0, lp1, lif1, lie1, lem1, fif1, fie1, h1};
   endfunction

   function automatic logic [31:0] o3();
      return {25'd0, lp3, lif3, lie3, lem3, fif3, fie3, h3};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rt = 5'd0;
      ex_mem_read = 1'b0; branch_taken_ex = 1'b0; mem_busy = 1'b0;
      halted_controller_id = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_b = 1'b1;
      idle();
      mid();
      chk("reset_outs", o1(), O_IDLE);
      step();
      rst_b = 1'b0;
   endtask

   // Watchdog: the directed sequence is short; anything beyond this is a hang.
   initial begin
      #100000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset ----------------
      do_reset();
      mid();
      chk("reset_state", 32'(st1), 32'(RUN));
      chk("reset_idle_outs", o1(), O_IDLE);
      step();

      // ---------------- load-use, single bubble ----------------
      ex_rt = 5'd8; ex_mem_read = 1'b1; id_rs = 5'd8;
      mid(); chk("lu_rs_stall", o1(), O_STALL); step();
      idle(); id_rs = 5'd8;
      mid(); chk("lu_release", o1(), O_IDLE); chk("lu_release_state", 32'(st1), 32'(RUN)); step();
      ex_rt = 5'd0; ex_mem_read = 1'b1; id_rs = 5'd0;
      mid(); chk("lu_zero_reg", o1(), O_IDLE); step();
      ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
      mid(); chk("lu_rt_unused", o1(), O_IDLE); step();
      id_uses_rt = 1'b1;
      mid(); chk("lu_rt_stall", o1(), O_STALL); step();
      mem_busy = 1'b1;
      mid(); chk("busy_in_run", o1(), O_BUSY); step();
      mem_busy = 1'b0;
      mid(); chk("busy_return_reeval", o1(), O_STALL); chk("busy_return_state", 32'(st1), 32'(MEM_WAIT)); step();
      idle();
      mid(); chk("after_busy_idle", o1(), O_IDLE); chk("after_busy_state", 32'(st1), 32'(RUN)); step();

      // ---------------- 3-cycle stall with memory wait inside ----------------
      do_reset();
      ex_rt = 5'd8; ex_mem_read = 1'b1; id_rs = 5'd8;
      mid(); chk("ls3_c0", o3(), O_STALL); step();
      mid(); chk("ls3_c1", o3(), O_STALL); chk("ls3_c1_state", 32'(st3), 32'(LOAD_STALL)); step();
      mem_busy = 1'b1;
      mid(); chk("ls3_busy0", o3(), O_BUSY); step();
      mid(); chk("ls3_busy1", o3(), O_BUSY); chk("ls3_busy_state", 32'(st3), 32'(MEM_WAIT)); step();
      mem_busy = 1'b0;
      mid(); chk("ls3_last_stall", o3(), O_STALL); step();
      idle();
      mid(); chk("ls3_done", o3(), O_IDLE); chk("ls3_done_state", 32'(st3), 32'(RUN)); step();

      // ---------------- branch overrides hazard and halt ----------------
      do_reset();
      branch_taken_ex = 1'b1; halted_controller_id = 1'b1;
      ex_rt = 5'd8; ex_mem_read = 1'b1; id_rs = 5'd8;
      mid(); chk("branch_flush", o1(), O_BRANCH); step();
      idle();
      mid(); chk("branch_after", o1(), O_IDLE); chk("branch_state", 32'(st1), 32'(RUN)); step();
      mid(); chk("branch_no_halt", o1(), O_IDLE); step();

      // ---------------- halt drain ----------------
      halted_controller_id = 1'b1;
      mid(); chk("halt_c0", o1(), O_DRAIN); step();
      halted_controller_id = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         mid();
         chk($sformatf("drain_c%0d", i), o1(), O_DRAIN);
         chk($sformatf("drain_state_c%0d", i), 32'(st1), 32'(DRAIN));
         step();
      end
      mid(); chk("halted_edge4", o1(), O_HALTED); chk("halted_state", 32'(st1), 32'(HALTED)); step();
      mem_busy = 1'b1; branch_taken_ex = 1'b1; ex_rt = 5'd8; ex_mem_read = 1'b1; id_rs = 5'd8;
      mid(); chk("halted_ignores_inputs", o1(), O_HALTED); step();
      idle(); halted_controller_id = 1'b1;
      mid(); chk("halted_sticky", o1(), O_HALTED); step();

      // ---------------- reset out of HALTED ----------------
      rst_b = 1'b1; idle();
      mid(); chk("rst_in_halted_outs", o1(), O_IDLE); step();
      rst_b = 1'b0;
      mid(); chk("post_rst_outs", o1(), O_IDLE); chk("post_rst_state", 32'(st1), 32'(RUN)); step();

`ifdef HAZARD_PERF_COUNT_EN
      // ---------------- performance counters ----------------
      mid(); chk("perf_stall_clear", sc1, 32'd0); chk("perf_flush_clear", fc1, 32'd0); step();
      ex_rt = 5'd8; ex_mem_read = 1'b1; id_rs = 5'd8;
      step();
      idle(); step();
      ex_rt = 5'd4; ex_mem_read = 1'b1; id_rt = 5'd4; id_uses_rt = 1'b1;
      step();
      idle(); branch_taken_ex = 1'b1;
      step();
      idle();
      mid(); chk("perf_stall_cycles", sc1, 32'd2); chk("perf_flush_count", fc1, 32'd1); step();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
